axi_slv_mem: RTL and testbench
==============================

// Module: axi_slv_mem
// PURPOSE
// - AXI slave memory endpoint. Sits directly downstream of the AXI master interface and consumes its AW/W/AR channels.
// - Answers with B/R channels from an internal word-addressed RAM.
// - Serves as the responder that the master-side driver and monitor exercise.
// - Write and read paths are independent FSMs. Each path allows one outstanding transaction.
// PARAMETERS
// ADDR_WIDTH  32    byte address width (awaddr/araddr)
// DATA_WIDTH  32    data bus width in bits; must be 32 or 64
// ID_WIDTH    4     transaction ID width
// MEM_DEPTH   1024  RAM depth in DATA_WIDTH words
// PORTS
// aclk     in   1              clock, all logic on rising edge
// aresetn  in   1              async active-low reset
// awid     in   ID_WIDTH       write address ID
// awaddr   in   ADDR_WIDTH     write start byte address
// awlen    in   8              beats-1
// awsize   in   3              log2 bytes per beat
// awburst  in   2              00 FIXED, 01 INCR, 10 WRAP, 11 reserved
// awvalid  in   1              write address valid
// awready  out  1              write address ready
// wid      in   ID_WIDTH       write data ID
// wdata    in   DATA_WIDTH     write data
// wstrb    in   DATA_WIDTH/8   byte strobes
// wlast    in   1              last write beat
// wvalid   in   1              write data valid
// wready   out  1              write data ready
// bid      out  ID_WIDTH       response ID (= captured awid)
// bresp    out  2              00 OKAY, 10 SLVERR
// bvalid   out  1              write response valid
// bready   in   1              write response ready
// arid     in   ID_WIDTH       read address ID
// araddr   in   ADDR_WIDTH     read start byte address
// arlen    in   8              beats-1
// arsize   in   3              log2 bytes per beat
// arburst  in   2              burst type, same coding as awburst
// arvalid  in   1              read address valid
// arready  out  1              read address ready
// rid      out  ID_WIDTH       read data ID (= captured arid)
// rdata    out  DATA_WIDTH     read data
// rresp    out  2              per-beat response
// rlast    out  1              final read beat
// rvalid   out  1              read data valid
// rready   in   1              read data ready
// BEHAVIOUR
// - Reset: every output 0; both FSMs go to IDLE. RAM contents are retained/undefined and are not cleared.
//   - Applies mid-burst too: the burst is abandoned, no B/R is issued.
//   - awready/arready rise on the first aclk edge after aresetn deasserts.
// - Write FSM W_IDLE -> W_DATA -> W_RESP -> W_IDLE.
//   - W_IDLE: awready=1. On awvalid&&awready, capture id/addr/len/size/burst, clear the beat counter and the err flag, go to W_DATA. awready drops the next cycle.
//   - W_DATA: wready=1. On each wvalid&&wready, write the bytes whose wstrb bit is set to mem[addr>>log2(DATA_WIDTH/8)], then advance addr.
//   - W_DATA ends on wlast, regardless of count: go to W_RESP.
//   - W_RESP: bvalid=1, bid=awid, bresp from err; held stable until bready, then go to W_IDLE. Minimum AW-to-B latency is beats+1 cycles.
// - Read FSM R_IDLE -> R_DATA -> R_IDLE.
//   - R_IDLE: arready=1. On handshake, capture fields and register beat 0 into rdata. rvalid=1 the following cycle.
//   - R_DATA: rdata/rresp/rlast stay stable while rvalid&&!rready.
//     - Each handshake loads the next beat.
//     - rlast=1 when the beat count equals arlen. The handshake on the rlast beat returns the FSM to R_IDLE.
// - Address advance per beat:
//   - FIXED: unchanged.
//   - INCR: addr += 1<<size.
//   - WRAP: see CONFIGURATION.
//   - No 4KB boundary check is performed.
// - Error rules, per transaction:
//   - A write sets err on any of: size > log2(DATA_WIDTH/8), reserved burst, word index >= MEM_DEPTH, wid != awid, or wlast asserted on a beat count != awlen. bresp is SLVERR when err is set.
//   - Writes to an out-of-range index are suppressed. Reads from an out-of-range index return rdata=0 with rresp=SLVERR for that beat only.
//   - A read with an illegal size or reserved burst returns SLVERR on every beat.
// - Simultaneous read and write to the same word in the same cycle: the read returns the old data.
// - The write and read paths never stall each other.
// CONFIGURATION
// - AXI_SLV_WRAP_BURST_EN defined:
//   - WRAP is legal only for len+1 in {2,4,8,16}; any other length is an error.
//   - Wrap boundary = addr & ~((len+1)*(1<<size)-1). The address wraps to the boundary when it passes boundary+span.
// - AXI_SLV_WRAP_BURST_EN undefined:
//   - WRAP is treated like a reserved burst.
//   - Writes: all beats are accepted and discarded, bresp=SLVERR.
//   - Reads: full arlen+1 beats are returned, each with rdata=0 and rresp=SLVERR.
// TESTING
// - INCR write awaddr=0x10, awlen=3, size=2, data 0xA0..A3, full strobes, then read back -> bresp=OKAY; rdata A0,A1,A2,A3; rlast on beat 3 only; rid=arid.
// - Write wstrb=4'b0101 data 0xFFFFFFFF over a word holding 0x12345678 -> read returns 0x12FF56FF.
// - Read of 2 beats with rready held low for 5 cycles on beat 0 -> rdata/rvalid stable for those 5 cycles; second beat follows the handshake.
// - Write at word index MEM_DEPTH (awaddr=MEM_DEPTH*4) -> bresp=SLVERR; memory unchanged; read there -> rdata=0, rresp=SLVERR.
// - WRAP awaddr=0x38, awlen=3, size=2: with the macro, beats hit 0x38,0x3C,0x30,0x34 and bresp=OKAY; without the macro, bresp=SLVERR.
// - aresetn pulsed low mid W_DATA (beat 1 of 4) -> bvalid never asserts; awready=1 one cycle after release; a new transaction completes OKAY.

Source files
------------

// File: rtl/axi_slv_mem.sv
// -----------------------------------------------------------------------------
// axi_slv_mem
// AXI slave memory endpoint. It takes the AW/W/AR channels from an upstream
// AXI master and answers on B/R from an internal word-addressed RAM.
// The write path and the read path are separate FSMs. Each path accepts one
// outstanding transaction, and neither path ever stalls the other.
//
// Build option:
//   AXI_SLV_WRAP_BURST_EN - when defined, WRAP bursts are supported for
//                           len+1 in {2,4,8,16}. When undefined, WRAP is
//                           treated as a reserved burst type (SLVERR).
//
// Parameters:
//   ADDR_WIDTH  byte address width
//   DATA_WIDTH  data bus width (32 or 64)
//   ID_WIDTH    transaction ID width
//   MEM_DEPTH   RAM depth in DATA_WIDTH words
//
// Ports:
//   aclk, aresetn                      clock, async active-low reset
//   aw* (awid..awvalid) / awready      write address channel
//   w*  (wid..wvalid)   / wready       write data channel
//   bid, bresp, bvalid  / bready       write response channel
//   ar* (arid..arvalid) / arready      read address channel
//   rid, rdata, rresp, rlast, rvalid / rready   read data channel
// -----------------------------------------------------------------------------
module axi_slv_mem #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int ID_WIDTH   = 4,
    parameter int MEM_DEPTH  = 1024
) (
    input  logic                    aclk,
    input  logic                    aresetn,
    // write address
    input  logic [ID_WIDTH-1:0]     awid,
    input  logic [ADDR_WIDTH-1:0]   awaddr,
    input  logic [7:0]              awlen,
    input  logic [2:0]              awsize,
    input  logic [1:0]              awburst,
    input  logic                    awvalid,
    output logic                    awready,
    // write data
    input  logic [ID_WIDTH-1:0]     wid,
    input  logic [DATA_WIDTH-1:0]   wdata,
    input  logic [DATA_WIDTH/8-1:0] wstrb,
    input  logic                    wlast,
    input  logic                    wvalid,
    output logic                    wready,
    // write response
    output logic [ID_WIDTH-1:0]     bid,
    output logic [1:0]              bresp,
    output logic                    bvalid,
    input  logic                    bready,
    // read address
    input  logic [ID_WIDTH-1:0]     arid,
    input  logic [ADDR_WIDTH-1:0]   araddr,
    input  logic [7:0]              arlen,
    input  logic [2:0]              arsize,
    input  logic [1:0]              arburst,
    input  logic                    arvalid,
    output logic                    arready,
    // read data
    output logic [ID_WIDTH-1:0]     rid,
    output logic [DATA_WIDTH-1:0]   rdata,
    output logic [1:0]              rresp,
    output logic                    rlast,
    output logic                    rvalid,
    input  logic                    rready
);

    localparam int STRB_W   = DATA_WIDTH / 8;
    localparam int BYTE_LSB = $clog2(STRB_W);
    localparam int MIDX_W   = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;

    localparam logic [1:0] BURST_FIXED = 2'b00;
    localparam logic [1:0] BURST_INCR  = 2'b01;
    localparam logic [1:0] BURST_WRAP  = 2'b10;
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {
        W_IDLE = 2'd0,
        W_DATA = 2'd1,
        W_RESP = 2'd2
    } w_state_e;

    typedef enum logic [0:0] {
        R_IDLE = 1'b0,
        R_DATA = 1'b1
    } r_state_e;

    // Transaction-level legality. A bad transaction answers SLVERR and never
    // touches the RAM.
    function automatic logic attr_err(input logic [7:0] len,
                                      input logic [2:0] size,
                                      input logic [1:0] burst);
        logic err;
        err = (size > 3'(BYTE_LSB));
        case (burst)
            BURST_FIXED: err = err;
            BURST_INCR:  err = err;
`ifdef AXI_SLV_WRAP_BURST_EN
            BURST_WRAP:  err = err | !((len == 8'd1) || (len == 8'd3) ||
                                       (len == 8'd7) || (len == 8'd15));
`else
            BURST_WRAP:  err = 1'b1 | (len == 8'd0);
`endif
            default:     err = 1'b1;
        endcase
        return err;
    endfunction

    // Address of the following beat. The WRAP result only matters when WRAP is
    // legal. Otherwise the beats are discarded or zeroed anyway.
    function automatic logic [ADDR_WIDTH-1:0] next_addr(input logic [ADDR_WIDTH-1:0] addr,
                                                        input logic [7:0]            len,
                                                        input logic [2:0]            size,
                                                        input logic [1:0]            burst);
        logic [ADDR_WIDTH-1:0] inc;
        logic [ADDR_WIDTH-1:0] span_mask;
        logic [ADDR_WIDTH-1:0] nxt;
        inc       = ADDR_WIDTH'(1) << size;
        span_mask = ((ADDR_WIDTH'(len) + ADDR_WIDTH'(1)) << size) - ADDR_WIDTH'(1);
        case (burst)
            BURST_FIXED: nxt = addr;
            BURST_INCR:  nxt = addr + inc;
            // Keep the bits above the wrap boundary and let the offset roll over.
            BURST_WRAP:  nxt = (addr & ~span_mask) | ((addr + inc) & span_mask);
            default:     nxt = addr;
        endcase
        return nxt;
    endfunction

    // RAM storage. It has no reset, so its contents survive aresetn.
    logic [DATA_WIDTH-1:0] mem_q [MEM_DEPTH];

    // ------------------------------------------------------------ write path
    w_state_e              w_state_q, w_state_d;
    logic [ID_WIDTH-1:0]   aw_id_q, aw_id_d;
    logic [ADDR_WIDTH-1:0] aw_addr_q, aw_addr_d;
    logic [7:0]            aw_len_q, aw_len_d;
    logic [2:0]            aw_size_q, aw_size_d;
    logic [1:0]            aw_burst_q, aw_burst_d;
    logic [7:0]            w_cnt_q, w_cnt_d;
    logic                  w_err_q, w_err_d;
    logic                  w_drop_q, w_drop_d;
    logic                  awready_q, awready_d;
    logic                  wready_q, wready_d;
    logic                  bvalid_q, bvalid_d;
    logic [1:0]            bresp_q, bresp_d;

    logic [ADDR_WIDTH-1:0] w_word_s;
    logic                  w_oob_s;
    logic                  w_beat_s;
    logic                  w_we_s;

    // Word index and range check for the current write beat.
    always_comb begin
        w_word_s = aw_addr_q >> BYTE_LSB;
        w_oob_s  = (w_word_s >= ADDR_WIDTH'(MEM_DEPTH));
        w_beat_s = (w_state_q == W_DATA) && wvalid && wready_q;
        w_we_s   = w_beat_s && !w_drop_q && !w_oob_s;
    end

    // Write FSM next state, captured AW fields, error tracking and output decode.
    always_comb begin
        w_state_d  = w_state_q;
        aw_id_d    = aw_id_q;
        aw_addr_d  = aw_addr_q;
        aw_len_d   = aw_len_q;
        aw_size_d  = aw_size_q;
        aw_burst_d = aw_burst_q;
        w_cnt_d    = w_cnt_q;
        w_err_d    = w_err_q;
        w_drop_d   = w_drop_q;
        case (w_state_q)
            W_IDLE: begin
                if (awvalid && awready_q) begin
                    w_state_d  = W_DATA;
                    aw_id_d    = awid;
                    aw_addr_d  = awaddr;
                    aw_len_d   = awlen;
                    aw_size_d  = awsize;
                    aw_burst_d = awburst;
                    w_cnt_d    = 8'd0;
                    w_drop_d   = attr_err(awlen, awsize, awburst);
                    w_err_d    = attr_err(awlen, awsize, awburst);
                end else begin
                    w_state_d = W_IDLE;
                end
            end
            W_DATA: begin
                if (w_beat_s) begin
                    aw_addr_d = next_addr(aw_addr_q, aw_len_q, aw_size_q, aw_burst_q);
                    w_cnt_d   = w_cnt_q + 8'd1;
                    w_err_d   = w_err_q | w_oob_s | (wid != aw_id_q) |
                                (wlast && (w_cnt_q != aw_len_q));
                    // wlast closes the burst, even if the beat count disagrees.
                    if (wlast) begin
                        w_state_d = W_RESP;
                    end else begin
                        w_state_d = W_DATA;
                    end
                end else begin
                    w_state_d = W_DATA;
                end
            end
            W_RESP: begin
                if (bvalid_q && bready) begin
                    w_state_d = W_IDLE;
                end else begin
                    w_state_d = W_RESP;
                end
            end
            default: begin
                w_state_d = W_IDLE;
            end
        endcase
        awready_d = (w_state_d == W_IDLE);
        wready_d  = (w_state_d == W_DATA);
        bvalid_d  = (w_state_d == W_RESP);
        bresp_d   = w_err_d ? RESP_SLVERR : RESP_OKAY;
    end

    // Write FSM state and write-side registered outputs.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            w_state_q  <= W_IDLE;
            aw_id_q    <= {ID_WIDTH{1'b0}};
            aw_addr_q  <= {ADDR_WIDTH{1'b0}};
            aw_len_q   <= 8'd0;
            aw_size_q  <= 3'd0;
            aw_burst_q <= 2'd0;
            w_cnt_q    <= 8'd0;
            w_err_q    <= 1'b0;
            w_drop_q   <= 1'b0;
            awready_q  <= 1'b0;
            wready_q   <= 1'b0;
            bvalid_q   <= 1'b0;
            bresp_q    <= 2'b00;
        end else begin
            w_state_q  <= w_state_d;
            aw_id_q    <= aw_id_d;
            aw_addr_q  <= aw_addr_d;
            aw_len_q   <= aw_len_d;
            aw_size_q  <= aw_size_d;
            aw_burst_q <= aw_burst_d;
            w_cnt_q    <= w_cnt_d;
            w_err_q    <= w_err_d;
            w_drop_q   <= w_drop_d;
            awready_q  <= awready_d;
            wready_q   <= wready_d;
            bvalid_q   <= bvalid_d;
            bresp_q    <= bresp_d;
        end
    end

    // Byte-masked RAM write.
    always_ff @(posedge aclk) begin
        if (w_we_s) begin
            for (int b = 0; b < STRB_W; b++) begin
                if (wstrb[b]) begin
                    mem_q[w_word_s[MIDX_W-1:0]][b*8 +: 8] <= wdata[b*8 +: 8];
                end
            end
        end
    end

    assign awready = awready_q;
    assign wready  = wready_q;
    assign bvalid  = bvalid_q;
    assign bresp   = bresp_q;
    assign bid     = aw_id_q;

    // ------------------------------------------------------------- read path
    r_state_e              r_state_q, r_state_d;
    logic [ID_WIDTH-1:0]   ar_id_q, ar_id_d;
    logic [ADDR_WIDTH-1:0] ar_addr_q, ar_addr_d;
    logic [7:0]            ar_len_q, ar_len_d;
    logic [2:0]            ar_size_q, ar_size_d;
    logic [1:0]            ar_burst_q, ar_burst_d;
    logic [7:0]            r_cnt_q, r_cnt_d;
    logic                  r_bad_q, r_bad_d;
    logic                  arready_q, arready_d;
    logic                  rvalid_q, rvalid_d;
    logic                  rlast_q, rlast_d;
    logic [DATA_WIDTH-1:0] rdata_q;
    logic [1:0]            rresp_q;

    logic                  r_load_s;
    logic [ADDR_WIDTH-1:0] r_laddr_s;
    logic                  r_lbad_s;
    logic [ADDR_WIDTH-1:0] r_word_s;
    logic                  r_oob_s;
    logic [ADDR_WIDTH-1:0] r_nxt_s;

    // Read FSM next state, plus selection of which beat (if any) loads into rdata.
    always_comb begin
        r_state_d  = r_state_q;
        ar_id_d    = ar_id_q;
        ar_addr_d  = ar_addr_q;
        ar_len_d   = ar_len_q;
        ar_size_d  = ar_size_q;
        ar_burst_d = ar_burst_q;
        r_cnt_d    = r_cnt_q;
        r_bad_d    = r_bad_q;
        rvalid_d   = rvalid_q;
        rlast_d    = rlast_q;
        r_load_s   = 1'b0;
        r_laddr_s  = ar_addr_q;
        r_lbad_s   = r_bad_q;
        r_nxt_s    = next_addr(ar_addr_q, ar_len_q, ar_size_q, ar_burst_q);
        case (r_state_q)
            R_IDLE: begin
                if (arvalid && arready_q) begin
                    // Beat 0 loads straight from the AR fields.
                    r_state_d  = R_DATA;
                    ar_id_d    = arid;
                    ar_addr_d  = araddr;
                    ar_len_d   = arlen;
                    ar_size_d  = arsize;
                    ar_burst_d = arburst;
                    r_cnt_d    = 8'd0;
                    r_bad_d    = attr_err(arlen, arsize, arburst);
                    rvalid_d   = 1'b1;
                    rlast_d    = (arlen == 8'd0);
                    r_load_s   = 1'b1;
                    r_laddr_s  = araddr;
                    r_lbad_s   = attr_err(arlen, arsize, arburst);
                end else begin
                    r_state_d = R_IDLE;
                end
            end
            R_DATA: begin
                if (rvalid_q && rready) begin
                    if (rlast_q) begin
                        r_state_d = R_IDLE;
                        rvalid_d  = 1'b0;
                        rlast_d   = 1'b0;
                    end else begin
                        ar_addr_d = r_nxt_s;
                        r_cnt_d   = r_cnt_q + 8'd1;
                        rlast_d   = ((r_cnt_q + 8'd1) == ar_len_q);
                        r_load_s  = 1'b1;
                        r_laddr_s = r_nxt_s;
                    end
                end else begin
                    r_state_d = R_DATA;
                end
            end
            default: begin
                r_state_d = R_IDLE;
                rvalid_d  = 1'b0;
                rlast_d   = 1'b0;
            end
        endcase
        arready_d = (r_state_d == R_IDLE);
        r_word_s  = r_laddr_s >> BYTE_LSB;
        r_oob_s   = (r_word_s >= ADDR_WIDTH'(MEM_DEPTH));
    end

    // Read FSM state and read-side registered outputs.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_state_q  <= R_IDLE;
            ar_id_q    <= {ID_WIDTH{1'b0}};
            ar_addr_q  <= {ADDR_WIDTH{1'b0}};
            ar_len_q   <= 8'd0;
            ar_size_q  <= 3'd0;
            ar_burst_q <= 2'd0;
            r_cnt_q    <= 8'd0;
            r_bad_q    <= 1'b0;
            arready_q  <= 1'b0;
            rvalid_q   <= 1'b0;
            rlast_q    <= 1'b0;
        end else begin
            r_state_q  <= r_state_d;
            ar_id_q    <= ar_id_d;
            ar_addr_q  <= ar_addr_d;
            ar_len_q   <= ar_len_d;
            ar_size_q  <= ar_size_d;
            ar_burst_q <= ar_burst_d;
            r_cnt_q    <= r_cnt_d;
            r_bad_q    <= r_bad_d;
            arready_q  <= arready_d;
            rvalid_q   <= rvalid_d;
            rlast_q    <= rlast_d;
        end
    end

    // Read data register. A write to the same word in the same cycle is
    // not visible yet, so this read returns the old data.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            rdata_q <= {DATA_WIDTH{1'b0}};
            rresp_q <= 2'b00;
        end else if (r_load_s) begin
            if (r_lbad_s || r_oob_s) begin
                rdata_q <= {DATA_WIDTH{1'b0}};
                rresp_q <= RESP_SLVERR;
            end else begin
                rdata_q <= mem_q[r_word_s[MIDX_W-1:0]];
                rresp_q <= RESP_OKAY;
            end
        end
    end

    assign arready = arready_q;
    assign rvalid  = rvalid_q;
    assign rlast   = rlast_q;
    assign rdata   = rdata_q;
    assign rresp   = rresp_q;
    assign rid     = ar_id_q;

endmodule

// File: tb/tb_axi_slv_mem.sv
// Directed bench for axi_slv_mem (default parameters).
module tb_axi_slv_mem;

    localparam logic [1:0] OKAY   = 2'b00;
    localparam logic [1:0] SLVERR = 2'b10;
    localparam logic [1:0] FIXED  = 2'b00;
    localparam logic [1:0] INCR   = 2'b01;
    localparam logic [1:0] WRAP   = 2'b10;

    logic        aclk;
    logic        aresetn;
    logic [3:0]  awid;
    logic [31:0] awaddr;
    logic [7:0]  awlen;
    logic [2:0]  awsize;
    logic [1:0]  awburst;
    logic        awvalid;
    logic        awready;
    logic [3:0]  wid;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wlast;
    logic        wvalid;
    logic        wready;
    logic [3:0]  bid;
    logic [1:0]  bresp;
    logic        bvalid;
    logic        bready;
    logic [3:0]  arid;
    logic [31:0] araddr;
    logic [7:0]  arlen;
    logic [2:0]  arsize;
    logic [1:0]  arburst;
    logic        arvalid;
    logic        arready;
    logic [3:0]  rid;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rlast;
    logic        rvalid;
    logic        rready;

    int checks   = 0;
    int failures = 0;

    axi_slv_mem dut (
        .aclk(aclk), .aresetn(aresetn),
        .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize),
        .awburst(awburst), .awvalid(awvalid), .awready(awready),
        .wid(wid), .wdata(wdata), .wstrb(wstrb), .wlast(wlast),
        .wvalid(wvalid), .wready(wready),
        .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready),
        .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize),
        .arburst(arburst), .arvalid(arvalid), .arready(arready),
        .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast),
        .rvalid(rvalid), .rready(rready)
    );

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic aw_send(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                           input logic [2:0] size, input logic [1:0] burst);
        int n;
        awid = id; awaddr = addr; awlen = len; awsize = size; awburst = burst; awvalid = 1'b1;
        n = 0;
        while (awready !== 1'b1 && n < 50) begin @(posedge aclk); #1; n++; end
        chk("aw_ready", 32'(awready), 32'd1);
        @(posedge aclk); #1;
        awvalid = 1'b0;
    endtask

    task automatic w_beat(input logic [3:0] id, input logic [31:0] data, input logic [3:0] strb,
                          input logic last);
        int n;
        wid = id; wdata = data; wstrb = strb; wlast = last; wvalid = 1'b1;
        n = 0;
        while (wready !== 1'b1 && n < 50) begin @(posedge aclk); #1; n++; end
        chk("w_ready", 32'(wready), 32'd1);
        @(posedge aclk); #1;
        wvalid = 1'b0; wlast = 1'b0;
    endtask

    task automatic wr_burst(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                            input logic [2:0] size, input logic [1:0] burst,
                            input logic [31:0] base, input logic [3:0] strb);
        aw_send(id, addr, len, size, burst);
        for (int i = 0; i <= int'(len); i++) begin
            w_beat(id, base + 32'(i), strb, (i == int'(len)));
        end
    endtask

    task automatic b_expect(input string tag, input logic [3:0] id, input logic [1:0] resp);
        int n;
        bready = 1'b1;
        n = 0;
        while (bvalid !== 1'b1 && n < 50) begin @(posedge aclk); #1; n++; end
        chk({tag, "_bvalid"}, 32'(bvalid), 32'd1);
        chk({tag, "_bid"}, 32'(bid), 32'(id));
        chk({tag, "_bresp"}, 32'(bresp), 32'(resp));
        @(posedge aclk); #1;
        bready = 1'b0;
        chk({tag, "_bvalid_drop"}, 32'(bvalid), 32'd0);
    endtask

    task automatic ar_send(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                           input logic [2:0] size, input logic [1:0] burst);
        int n;
        arid = id; araddr = addr; arlen = len; arsize = size; arburst = burst; arvalid = 1'b1;
        n = 0;
        while (arready !== 1'b1 && n < 50) begin @(posedge aclk); #1; n++; end
        chk("ar_ready", 32'(arready), 32'd1);
        @(posedge aclk); #1;
        arvalid = 1'b0;
    endtask

    task automatic r_expect(input string tag, input logic [3:0] id, input logic [31:0] data,
                            input logic [1:0] resp, input logic last);
        int n;
        rready = 1'b1;
        n = 0;
        while (rvalid !== 1'b1 && n < 50) begin @(posedge aclk); #1; n++; end
        chk({tag, "_rvalid"}, 32'(rvalid), 32'd1);
        chk({tag, "_rdata"}, rdata, data);
        chk({tag, "_rresp"}, 32'(rresp), 32'(resp));
        chk({tag, "_rlast"}, 32'(rlast), 32'(last));
        chk({tag, "_rid"}, 32'(rid), 32'(id));
        @(posedge aclk); #1;
        rready = 1'b0;
    endtask

    initial begin
        aresetn = 1'b0;
        awid = 4'd0; awaddr = 32'd0; awlen = 8'd0; awsize = 3'd0; awburst = 2'd0; awvalid = 1'b0;
        wid = 4'd0; wdata = 32'd0; wstrb = 4'd0; wlast = 1'b0; wvalid = 1'b0;
        bready = 1'b0;
        arid = 4'd0; araddr = 32'd0; arlen = 8'd0; arsize = 3'd0; arburst = 2'd0; arvalid = 1'b0;
        rready = 1'b0;

        // Reset state
        repeat (3) @(posedge aclk);
        #1;
        chk("rst_awready", 32'(awready), 32'd0);
        chk("rst_arready", 32'(arready), 32'd0);
        chk("rst_wready", 32'(wready), 32'd0);
        chk("rst_bvalid", 32'(bvalid), 32'd0);
        chk("rst_rvalid", 32'(rvalid), 32'd0);
        chk("rst_rlast", 32'(rlast), 32'd0);
        chk("rst_rdata", rdata, 32'd0);
        aresetn = 1'b1;
        #1;
        chk("rel_awready_low", 32'(awready), 32'd0);
        @(posedge aclk); #1;
        chk("rel_awready_high", 32'(awready), 32'd1);
        chk("rel_arready_high", 32'(arready), 32'd1);

        // INCR write and read back
        wr_burst(4'h3, 32'h10, 8'd3, 3'd2, INCR, 32'hA0, 4'hF);
        b_expect("incr_w", 4'h3, OKAY);
        ar_send(4'h5, 32'h10, 8'd3, 3'd2, INCR);
        for (int i = 0; i < 4; i++) begin
            r_expect("incr_r", 4'h5, 32'hA0 + 32'(i), OKAY, (i == 3));
        end

        // Partial strobe merge
        wr_burst(4'h1, 32'h40, 8'd0, 3'd2, INCR, 32'h12345678, 4'hF);
        b_expect("strb_init", 4'h1, OKAY);
        wr_burst(4'h1, 32'h40, 8'd0, 3'd2, INCR, 32'hFFFFFFFF, 4'b0101);
        b_expect("strb_w", 4'h1, OKAY);
        ar_send(4'h2, 32'h40, 8'd0, 3'd2, INCR);
        r_expect("strb_r", 4'h2, 32'h12FF56FF, OKAY, 1'b1);

        // Read backpressure: beat 0 held for 5 cycles
        ar_send(4'h6, 32'h10, 8'd1, 3'd2, INCR);
        for (int i = 0; i < 5; i++) begin
            chk("hold_rvalid", 32'(rvalid), 32'd1);
            chk("hold_rdata", rdata, 32'hA0);
            chk("hold_rlast", 32'(rlast), 32'd0);
            @(posedge aclk); #1;
        end
        r_expect("hold_b0", 4'h6, 32'hA0, OKAY, 1'b0);
        r_expect("hold_b1", 4'h6, 32'hA1, OKAY, 1'b1);

        // Out-of-range word index: write suppressed (no alias onto word 0)
        wr_burst(4'h2, 32'h0, 8'd0, 3'd2, INCR, 32'hCAFEF00D, 4'hF);
        b_expect("oob_pre", 4'h2, OKAY);
        wr_burst(4'h2, 32'd4096, 8'd0, 3'd2, INCR, 32'hDEADBEEF, 4'hF);
        b_expect("oob_w", 4'h2, SLVERR);
        ar_send(4'h2, 32'h0, 8'd0, 3'd2, INCR);
        r_expect("oob_alias", 4'h2, 32'hCAFEF00D, OKAY, 1'b1);
        ar_send(4'h2, 32'd4096, 8'd0, 3'd2, INCR);
        r_expect("oob_r", 4'h2, 32'h0, SLVERR, 1'b1);
        // Burst crossing the top: only the out-of-range beat errors
        wr_burst(4'h2, 32'd4092, 8'd0, 3'd2, INCR, 32'h5555AAAA, 4'hF);
        b_expect("top_w", 4'h2, OKAY);
        ar_send(4'h7, 32'd4092, 8'd1, 3'd2, INCR);
        r_expect("top_b0", 4'h7, 32'h5555AAAA, OKAY, 1'b0);
        r_expect("top_b1", 4'h7, 32'h0, SLVERR, 1'b1);

        // Protocol errors on writes, illegal size on reads
        aw_send(4'h7, 32'h60, 8'd0, 3'd2, INCR);
        w_beat(4'h8, 32'h1, 4'hF, 1'b1);
        b_expect("wid_err", 4'h7, SLVERR);
        aw_send(4'h9, 32'h60, 8'd2, 3'd2, INCR);
        w_beat(4'h9, 32'h2, 4'hF, 1'b1);
        b_expect("early_wlast", 4'h9, SLVERR);
        ar_send(4'hA, 32'h10, 8'd1, 3'd3, INCR);
        r_expect("bad_size_b0", 4'hA, 32'h0, SLVERR, 1'b0);
        r_expect("bad_size_b1", 4'hA, 32'h0, SLVERR, 1'b1);

        // FIXED burst: both beats land on the same word
        wr_burst(4'hB, 32'h50, 8'd1, 3'd2, FIXED, 32'hD0, 4'hF);
        b_expect("fixed_w", 4'hB, OKAY);
        ar_send(4'hB, 32'h50, 8'd0, 3'd2, INCR);
        r_expect("fixed_r", 4'hB, 32'hD1, OKAY, 1'b1);

        // WRAP burst starting at 0x38
        wr_burst(4'hC, 32'h30, 8'd3, 3'd2, INCR, 32'hC0, 4'hF);
        b_expect("wrap_pre", 4'hC, OKAY);
        wr_burst(4'hC, 32'h38, 8'd3, 3'd2, WRAP, 32'hB0, 4'hF);
`ifdef AXI_SLV_WRAP_BURST_EN
        b_expect("wrap_w", 4'hC, OKAY);
        ar_send(4'hD, 32'h30, 8'd3, 3'd2, INCR);
        r_expect("wrap_mem0", 4'hD, 32'hB2, OKAY, 1'b0);
        r_expect("wrap_mem1", 4'hD, 32'hB3, OKAY, 1'b0);
        r_expect("wrap_mem2", 4'hD, 32'hB0, OKAY, 1'b0);
        r_expect("wrap_mem3", 4'hD, 32'hB1, OKAY, 1'b1);
        ar_send(4'hE, 32'h38, 8'd3, 3'd2, WRAP);
        for (int i = 0; i < 4; i++) begin
            r_expect("wrap_r", 4'hE, 32'hB0 + 32'(i), OKAY, (i == 3));
        end
`else
        b_expect("wrap_w", 4'hC, SLVERR);
        ar_send(4'hD, 32'h30, 8'd3, 3'd2, INCR);
        for (int i = 0; i < 4; i++) begin
            r_expect("wrap_mem", 4'hD, 32'hC0 + 32'(i), OKAY, (i == 3));
        end
        ar_send(4'hE, 32'h38, 8'd3, 3'd2, WRAP);
        for (int i = 0; i < 4; i++) begin
            r_expect("wrap_r", 4'hE, 32'h0, SLVERR, (i == 3));
        end
`endif

        // Reset in the middle of a write burst
        aw_send(4'h4, 32'h80, 8'd3, 3'd2, INCR);
        w_beat(4'h4, 32'h11, 4'hF, 1'b0);
        wid = 4'h4; wdata = 32'h12; wstrb = 4'hF; wlast = 1'b0; wvalid = 1'b1;
        aresetn = 1'b0;
        #1;
        chk("mid_rst_wready", 32'(wready), 32'd0);
        chk("mid_rst_bvalid", 32'(bvalid), 32'd0);
        chk("mid_rst_awready", 32'(awready), 32'd0);
        wvalid = 1'b0;
        repeat (2) @(posedge aclk);
        #1;
        aresetn = 1'b1;
        #1;
        chk("mid_rel_awready_low", 32'(awready), 32'd0);
        @(posedge aclk); #1;
        chk("mid_rel_awready_high", 32'(awready), 32'd1);
        for (int i = 0; i < 3; i++) begin
            chk("mid_no_bvalid", 32'(bvalid), 32'd0);
            @(posedge aclk); #1;
        end
        wr_burst(4'h4, 32'h80, 8'd0, 3'd2, INCR, 32'h77, 4'hF);
        b_expect("post_rst_w", 4'h4, OKAY);
        ar_send(4'h4, 32'h80, 8'd0, 3'd2, INCR);
        r_expect("post_rst_r", 4'h4, 32'h77, OKAY, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
